// File: rtl/contador_regressivo_m_if.sv
// Control/status bundle for the loadable modulo-M down counter.
interface contador_regressivo_m_if #(
  parameter int unsigned N = 7
);
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] valor;
  logic         inicia;
  logic         conta;
  logic [N-1:0] Q;
  logic         fim;
  logic         meio;
  logic         ativo;
  logic         pronto;

  // Control unit side: drives commands, observes count and status pulses.
  modport master (
    output zera_s, carrega, valor, inicia, conta,
    input  Q, fim, meio, ativo, pronto
  );

  // Counter side.
  modport slave (
    input  zera_s, carrega, valor, inicia, conta,
    output Q, fim, meio, ativo, pronto
  );
endinterface

// File: rtl/contador_regressivo_m.sv
// Loadable modulo-M down counter with control FSM; registered count,
// one-cycle fim/meio pulses, and state-decoded ativo/pronto flags.
module contador_regressivo_m #(
  parameter int unsigned M = 100,
  parameter int unsigned N = 7
) (
  input  logic                     clock,
  input  logic                     zera_as_n,
  contador_regressivo_m_if.slave   bus
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] PRONTO   = 2'd1;
  localparam logic [1:0] CONTANDO = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  // Largest loadable value; loads above it saturate here.
  localparam logic [N-1:0] VALOR_MAX = N'(M - 1);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] carga_q, carga_d;
  logic         fim_q, fim_d;
  logic         meio_q, meio_d;
  logic         ativo_q, pronto_q;
  logic [N-1:0] valor_sat;
  logic [N-1:0] q_dec;
  logic [N-1:0] metade;

  assign valor_sat = (bus.valor > VALOR_MAX) ? VALOR_MAX : bus.valor;
  assign q_dec     = q_q - N'(1);
  assign metade    = carga_q >> 1;

  // Next-state and next-count logic; command priority zera_s > carrega > inicia > conta.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    carga_d = carga_q;
    fim_d   = 1'b0;
    meio_d  = 1'b0;
    if (bus.zera_s) begin
      state_d = OCIOSO;
      q_d     = '0;
      carga_d = '0;
    end else if (bus.carrega) begin
      carga_d = valor_sat;
      q_d     = valor_sat;
      state_d = PRONTO;
    end else if (bus.inicia && (state_q == PRONTO || state_q == FIM)) begin
      q_d = carga_q;
      if (carga_q == '0) begin
        state_d = FIM;
        fim_d   = 1'b1;
      end else begin
        state_d = CONTANDO;
      end
    end else if (bus.conta && state_q == CONTANDO) begin
      // Guard keeps Q from wrapping even if CONTANDO were entered at zero.
      if (q_q != '0) begin
        q_d = q_dec;
        if (q_q == N'(1)) begin
          fim_d   = 1'b1;
          state_d = FIM;
        end else if (carga_q >= N'(2) && q_dec == metade) begin
          meio_d = 1'b1;
        end
      end
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      state_q  <= OCIOSO;
      q_q      <= '0;
      carga_q  <= '0;
      fim_q    <= 1'b0;
      meio_q   <= 1'b0;
      ativo_q  <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      carga_q  <= carga_d;
      fim_q    <= fim_d;
      meio_q   <= meio_d;
      ativo_q  <= (state_d == CONTANDO);
      pronto_q <= (state_d == PRONTO);
    end
  end

  assign bus.Q      = q_q;
  assign bus.fim    = fim_q;
  assign bus.meio   = meio_q;
  assign bus.ativo  = ativo_q;
  assign bus.pronto = pronto_q;

endmodule

// File: tb/tb_contador_regressivo_m.sv
// Scoreboard bench for contador_regressivo_m: driver pushes model predictions,
// monitor pops and compares one vector per clock.
module tb_contador_regressivo_m;

  localparam int unsigned M = 100;
  localparam int unsigned N = 7;

  typedef struct packed {
    logic [N-1:0] q;
    logic         fim;
    logic         meio;
    logic         ativo;
    logic         pronto;
  } exp_t;

  logic clk;
  logic rst_n;
  contador_regressivo_m_if #(.N(N)) bus ();

  contador_regressivo_m #(.M(M), .N(N)) dut (
    .clock     (clk),
    .zera_as_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: mode 0 idle, 1 loaded, 2 counting, 3 done.
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_carga = 0;

  function automatic exp_t model_step(input bit zs, input bit ca, input int va,
                                      input bit in, input bit co);
    exp_t e;
    bit f = 0;
    bit h = 0;
    if (zs) begin
      m_mode = 0; m_cnt = 0; m_carga = 0;
    end else if (ca) begin
      m_carga = (va > int'(M) - 1) ? int'(M) - 1 : va;
      m_cnt   = m_carga;
      m_mode  = 1;
    end else if (in && (m_mode == 1 || m_mode == 3)) begin
      m_cnt = m_carga;
      if (m_carga == 0) begin m_mode = 3; f = 1; end
      else m_mode = 2;
    end else if (co && m_mode == 2) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_mode = 3; f = 1; end
      else if (m_carga >= 2 && m_cnt == m_carga / 2) h = 1;
    end
    e.q      = N'(m_cnt);
    e.fim    = f;
    e.meio   = h;
    e.ativo  = (m_mode == 2);
    e.pronto = (m_mode == 1);
    return e;
  endfunction

  task automatic step(input bit zs, input bit ca, input int va,
                      input bit in, input bit co);
    @(negedge clk);
    bus.zera_s  = zs;
    bus.carrega = ca;
    bus.valor   = N'(va);
    bus.inicia  = in;
    bus.conta   = co;
    exp_q.push_back(model_step(zs, ca, va, in, co));
  endtask

  task automatic compare(input string name, input exp_t e);
    n_vec++;
    if (bus.Q !== e.q || bus.fim !== e.fim || bus.meio !== e.meio ||
        bus.ativo !== e.ativo || bus.pronto !== e.pronto) begin
      n_miss++;
      $display("FAIL %s @%0t: got Q=%0d fim=%b meio=%b ativo=%b pronto=%b, required Q=%0d fim=%b meio=%b ativo=%b pronto=%b",
               name, $time, bus.Q, bus.fim, bus.meio, bus.ativo, bus.pronto,
               e.q, e.fim, e.meio, e.ativo, e.pronto);
    end
  endtask

  // Monitor: one output vector presented per clock after each driven cycle.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) compare("vec", exp_q.pop_front());
  end

  task automatic async_reset_check();
    exp_t z;
    z = '0;
    @(negedge clk);
    bus.zera_s = 0; bus.carrega = 0; bus.inicia = 0; bus.conta = 0;
    #1 rst_n = 1'b0;
    #1 compare("async_reset", z);
    m_mode = 0; m_cnt = 0; m_carga = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t z;
    z = '0;
    rst_n = 1'b0;
    bus.zera_s = 0; bus.carrega = 0; bus.valor = '0; bus.inicia = 0; bus.conta = 0;
    #3 compare("reset_state", z);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic count from 5; conta alongside inicia is not counted.
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 1);
    repeat (7) step(0, 0, 0, 0, 1);
    // Saturation and zero load.
    step(0, 1, 120, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    // Gating.
    step(0, 1, 10, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 1);
    // Priority.
    step(1, 1, 9, 0, 0);
    step(0, 1, 7, 1, 0);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 1, 4, 0, 1);
    step(0, 0, 0, 0, 1);
    // Restart from FIM.
    step(0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    // Async reset mid-count at Q=6.
    step(0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    async_reset_check();
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);

    // Randomized traffic with short loads to exercise fim/meio often.
    for (int i = 0; i < 600; i++) begin
      int r;
      bit zs, ca, in, co;
      int va;
      r  = $urandom_range(0, 99);
      zs = (r < 2);
      ca = ($urandom_range(0, 99) < 8);
      in = ($urandom_range(0, 99) < 10);
      co = ($urandom_range(0, 99) < 65);
      va = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 8);
      step(zs, ca, va, in, co);
    end

    @(negedge clk);
    bus.zera_s = 0; bus.carrega = 0; bus.inicia = 0; bus.conta = 0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
